// File: rtl/sargantana_icache_pkg.sv
// Shared icache types: data-array line/parity typedefs, init FSM states, parity helper.
package sargantana_icache_pkg;

  localparam int IDATA_LINE_W = 128;
  localparam int IDATA_WORD_W = 32;
  localparam int IDATA_N_WORD = IDATA_LINE_W / IDATA_WORD_W;

  // Widest parity granule the helper accepts; narrower words are zero-extended,
  // which leaves their parity unchanged.
  localparam int PAR_MAX_W = 64;

  typedef logic [IDATA_LINE_W-1:0] idata_line_t;
  typedef logic [IDATA_N_WORD-1:0] idata_par_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } idata_init_state_e;

  // Even parity bit: makes the total number of ones (word + bit) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/sargantana_idata_way_bank.sv
// One icache way: N_SETS x (line + per-word parity) single-port store with
// word-enable writes, a registered read port and a combinational parity check.
module sargantana_idata_way_bank
  import sargantana_icache_pkg::*;
#(
  parameter int N_SETS = 64,
  parameter int LINE_W = 128,
  parameter int WORD_W = 32,
  localparam int N_WORD = LINE_W / WORD_W,
  localparam int IDX_W  = $clog2(N_SETS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [N_WORD-1:0] wmask,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LINE_W-1:0] wdata,
  input  logic [N_WORD-1:0] wpar,
  output logic [LINE_W-1:0] rdata,
  output logic              perr
);

  logic [LINE_W-1:0] mem [N_SETS];
  logic [N_WORD-1:0] par [N_SETS];
  logic [LINE_W-1:0] rdata_p1;
  logic [N_WORD-1:0] rpar_p1;

  // Word-granular write of data and its stored parity bit
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int w = 0; w < N_WORD; w++) begin
        if (wmask[w]) begin
          mem[addr][w*WORD_W +: WORD_W] <= wdata[w*WORD_W +: WORD_W];
          par[addr][w]                  <= wpar[w];
        end
      end
    end
  end

  // Stage 1: read register, updated only by a read to this way so it holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_p1 <= '0;
      rpar_p1  <= '0;
    end else if (en && !we) begin
      rdata_p1 <= mem[addr];
      rpar_p1  <= par[addr];
    end
  end

  // Recompute parity per word and flag any disagreement with the stored bit
  always_comb begin
    perr = 1'b0;
    for (int w = 0; w < N_WORD; w++) begin
      perr = perr | (even_parity(PAR_MAX_W'(rdata_p1[w*WORD_W +: WORD_W])) != rpar_p1[w]);
    end
  end

  assign rdata = rdata_p1;

endmodule

// File: rtl/sargantana_idata_memory_banked.sv
// N-way icache data array: init/flush sweep FSM, sweep-vs-user write mux,
// per-way banks and an optional output register stage.
module sargantana_idata_memory_banked
  import sargantana_icache_pkg::*;
#(
  parameter int N_WAY   = 4,
  parameter int N_SETS  = 64,
  parameter int LINE_W  = 128,
  parameter int WORD_W  = 32,
  parameter int OUT_REG = 0,
  localparam int N_WORD = LINE_W / WORD_W,
  localparam int IDX_W  = $clog2(N_SETS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_WAY-1:0]             req_i,
  input  logic                         we_i,
  input  logic [N_WORD-1:0]            wmask_i,
  input  logic [IDX_W-1:0]             addr_i,
  input  logic [LINE_W-1:0]            data_i,
  input  logic                         perr_inj_i,
  input  logic                         flush_i,
  output logic                         ready_o,
  output logic                         rvalid_o,
  output logic [N_WAY-1:0][LINE_W-1:0] data_way_o,
  output logic [N_WAY-1:0]             perr_way_o,
  output logic                         init_done_o
);

  localparam logic [IDX_W:0] LAST_SET = (IDX_W+1)'(N_SETS - 1);

  idata_init_state_e state_q, state_d;
  logic [IDX_W:0]    cnt_q, cnt_d;

  logic                         accept;
  logic [N_WORD-1:0]            user_par;
  logic [N_WAY-1:0]             bank_en;
  logic                         bank_we;
  logic [N_WORD-1:0]            bank_mask;
  logic [IDX_W-1:0]             bank_addr;
  logic [LINE_W-1:0]            bank_wdata;
  logic [N_WORD-1:0]            bank_wpar;
  logic [N_WAY-1:0][LINE_W-1:0] bank_rdata;
  logic [N_WAY-1:0]             bank_perr;

  logic                         vld_p1;
  logic [N_WAY-1:0]             req_p1;

  assign ready_o     = (state_q == RUN);
  assign init_done_o = (state_q == RUN);
  assign accept      = ready_o && (|req_i);

  // Sweep state and set counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep walks every set once; flush restarts it from set 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (flush_i) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_SET) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Even parity of user write words, with word 0 optionally corrupted for DFT
  always_comb begin
    user_par = '0;
    for (int w = 0; w < N_WORD; w++) begin
      user_par[w] = even_parity(PAR_MAX_W'(data_i[w*WORD_W +: WORD_W]));
    end
    user_par[0] = user_par[0] ^ perr_inj_i;
  end

  // Bank port mux: the sweep owns every way while initialising
  always_comb begin
    bank_en    = accept ? req_i : '0;
    bank_we    = we_i;
    bank_mask  = wmask_i;
    bank_addr  = addr_i;
    bank_wdata = data_i;
    bank_wpar  = user_par;
    if (state_q == INIT) begin
      bank_en    = '1;
      bank_we    = 1'b1;
      bank_mask  = '1;
      bank_addr  = cnt_q[IDX_W-1:0];
      bank_wdata = '0;
      bank_wpar  = '0;
    end
  end

  for (genvar i = 0; i < N_WAY; i++) begin : g_way
    sargantana_idata_way_bank #(
      .N_SETS (N_SETS),
      .LINE_W (LINE_W),
      .WORD_W (WORD_W)
    ) u_bank (
      .clk   (clk_i),
      .rst   (rst_i),
      .en    (bank_en[i]),
      .we    (bank_we),
      .wmask (bank_mask),
      .addr  (bank_addr),
      .wdata (bank_wdata),
      .wpar  (bank_wpar),
      .rdata (bank_rdata[i]),
      .perr  (bank_perr[i])
    );
  end

  // Stage 1: read valid and requested-way mask travel with the bank read registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
      req_p1 <= '0;
    end else begin
      vld_p1 <= accept && !we_i;
      req_p1 <= (accept && !we_i) ? req_i : '0;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                         vld_p2;
    logic [N_WAY-1:0]             perr_p2;
    logic [N_WAY-1:0][LINE_W-1:0] data_p2;

    // Stage 2: optional output register; only requested ways capture new data
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        vld_p2  <= 1'b0;
        perr_p2 <= '0;
        data_p2 <= '0;
      end else begin
        vld_p2  <= vld_p1;
        perr_p2 <= vld_p1 ? (bank_perr & req_p1) : '0;
        for (int i = 0; i < N_WAY; i++) begin
          if (vld_p1 && req_p1[i]) data_p2[i] <= bank_rdata[i];
        end
      end
    end

    assign rvalid_o   = vld_p2;
    assign perr_way_o = vld_p2 ? perr_p2 : '0;
    assign data_way_o = data_p2;
  end else begin : g_no_out_reg
    assign rvalid_o   = vld_p1;
    assign perr_way_o = vld_p1 ? (bank_perr & req_p1) : '0;
    assign data_way_o = bank_rdata;
  end

endmodule

// File: tb/tb_sargantana_idata_memory_banked.sv
// Self-checking bench for the banked icache data array against a line/flag model.
module tb_sargantana_idata_memory_banked;

  localparam int N_WAY   = 4;
  localparam int N_SETS  = 64;
  localparam int LINE_W  = 128;
  localparam int WORD_W  = 32;
  localparam int N_WORD  = LINE_W / WORD_W;
  localparam int IDX_W   = 6;
  localparam int OUT_REG = 0;
  localparam int RL      = 1 + OUT_REG;

  localparam logic [LINE_W-1:0] PAT = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [N_WAY-1:0]             req;
  logic                         we;
  logic [N_WORD-1:0]            wmask;
  logic [IDX_W-1:0]             addr;
  logic [LINE_W-1:0]            data;
  logic                         perr_inj;
  logic                         flush;
  logic                         ready;
  logic                         rvalid;
  logic [N_WAY-1:0][LINE_W-1:0] data_way;
  logic [N_WAY-1:0]             perr_way;
  logic                         init_done;

  int errors = 0;
  int checks = 0;

  // Reference model: stored line per way/set, plus whether word 0 parity is corrupt
  logic [LINE_W-1:0] mdl [N_WAY][N_SETS];
  logic              mcor [N_WAY][N_SETS];
  logic [LINE_W-1:0] last_out [N_WAY];

  sargantana_idata_memory_banked #(
    .N_WAY   (N_WAY),
    .N_SETS  (N_SETS),
    .LINE_W  (LINE_W),
    .WORD_W  (WORD_W),
    .OUT_REG (OUT_REG)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .we_i        (we),
    .wmask_i     (wmask),
    .addr_i      (addr),
    .data_i      (data),
    .perr_inj_i  (perr_inj),
    .flush_i     (flush),
    .ready_o     (ready),
    .rvalid_o    (rvalid),
    .data_way_o  (data_way),
    .perr_way_o  (perr_way),
    .init_done_o (init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (time=%0t)", $time);
    $fatal(1);
  end

  task automatic idle();
    req = '0; we = 1'b0; wmask = '0; addr = '0; data = '0; perr_inj = 1'b0; flush = 1'b0;
  endtask

  task automatic model_clear(input logic clear_out);
    for (int i = 0; i < N_WAY; i++) begin
      for (int s = 0; s < N_SETS; s++) begin
        mdl[i][s]  = '0;
        mcor[i][s] = 1'b0;
      end
      if (clear_out) last_out[i] = '0;
    end
  endtask

  task automatic do_write(input logic [N_WAY-1:0] r, input logic [IDX_W-1:0] a,
                          input logic [LINE_W-1:0] d, input logic [N_WORD-1:0] m, input logic inj);
    req = r; we = 1'b1; addr = a; data = d; wmask = m; perr_inj = inj;
    @(posedge clk); #1;
    idle();
    for (int i = 0; i < N_WAY; i++) begin
      if (r[i]) begin
        for (int w = 0; w < N_WORD; w++) begin
          if (m[w]) begin
            mdl[i][a][w*WORD_W +: WORD_W] = d[w*WORD_W +: WORD_W];
            if (w == 0) mcor[i][a] = inj;
          end
        end
      end
    end
    checks++;
    if (rvalid !== 1'b0) begin
      errors++; $display("FAIL write_no_rvalid set=%0d: rvalid=%b required 0", a, rvalid);
    end
  endtask

  task automatic do_read(input logic [N_WAY-1:0] r, input logic [IDX_W-1:0] a,
                         input string name, output logic [N_WAY-1:0] perr_seen);
    logic [N_WAY-1:0] exp_perr;
    req = r; we = 1'b0; addr = a;
    @(posedge clk); #1;
    idle();
    repeat (RL - 1) begin @(posedge clk); #1; end
    exp_perr = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (r[i]) begin
        last_out[i] = mdl[i][a];
        exp_perr[i] = mcor[i][a];
      end
    end
    perr_seen = perr_way;
    checks++;
    if (rvalid !== 1'b1) begin
      errors++; $display("FAIL %s rvalid set=%0d: got %b required 1", name, a, rvalid);
    end
    for (int i = 0; i < N_WAY; i++) begin
      checks++;
      if (data_way[i] !== last_out[i]) begin
        errors++;
        $display("FAIL %s data way=%0d set=%0d: got %h required %h", name, i, a, data_way[i], last_out[i]);
      end
    end
    checks++;
    if (perr_way !== exp_perr) begin
      errors++; $display("FAIL %s perr set=%0d: got %b required %b", name, a, perr_way, exp_perr);
    end
    @(posedge clk); #1;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++; $display("FAIL %s rvalid_pulse set=%0d: got %b required 0", name, a, rvalid);
    end
  endtask

  task automatic read_all(input string name);
    logic [N_WAY-1:0] p;
    for (int s = 0; s < N_SETS; s++) do_read('1, IDX_W'(s), name, p);
  endtask

  // Counts edges from now until ready rises; returns the edge count (bounded)
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0 || init_done !== 1'b0 || rvalid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: ready=%b init_done=%b rvalid=%b required 0/0/0", ready, init_done, rvalid);
    end
    checks++;
    if (data_way !== '0 || perr_way !== '0) begin
      errors++; $display("FAIL reset_data: data=%h perr=%b required 0", data_way, perr_way);
    end
    rst = 1'b0;
    model_clear(1'b1);
    wait_ready(n);
    checks++;
    if (n !== N_SETS) begin
      errors++; $display("FAIL reset_sweep_len: ready after %0d edges required %0d", n, N_SETS);
    end
    checks++;
    if (init_done !== 1'b1) begin
      errors++; $display("FAIL reset_init_done: got %b required 1", init_done);
    end
    read_all("reset_zero");
  endtask

  task automatic test_basic();
    logic [N_WAY-1:0] p;
    do_write(4'b0101, 6'd5, PAT, 4'hF, 1'b0);
    do_read(4'hF, 6'd5, "basic", p);
    checks++;
    if (data_way[0] !== PAT || data_way[2] !== PAT || data_way[1] !== '0 || data_way[3] !== '0) begin
      errors++; $display("FAIL basic_literal: got %h required ways0/2=%h ways1/3=0", data_way, PAT);
    end
  endtask

  task automatic test_partial();
    logic [N_WAY-1:0] p;
    do_write(4'b0010, 6'd9, '1, 4'b0010, 1'b0);
    do_read(4'b0010, 6'd9, "partial", p);
    checks++;
    if (data_way[1] !== 128'h00000000_00000000_FFFFFFFF_00000000) begin
      errors++; $display("FAIL partial_literal: got %h required 00000000_00000000_ffffffff_00000000", data_way[1]);
    end
  endtask

  task automatic test_parity_inject();
    logic [N_WAY-1:0] p;
    do_write(4'b1000, 6'd0, {$urandom, $urandom, $urandom, $urandom}, 4'hF, 1'b1);
    do_read(4'hF, 6'd0, "perr_inj", p);
    checks++;
    if (p !== 4'b1000) begin
      errors++; $display("FAIL perr_inj_literal: got %b required 1000", p);
    end
    do_write(4'b1000, 6'd0, {$urandom, $urandom, $urandom, $urandom}, 4'hF, 1'b0);
    do_read(4'hF, 6'd0, "perr_clear", p);
    checks++;
    if (p !== 4'b0000) begin
      errors++; $display("FAIL perr_clear_literal: got %b required 0000", p);
    end
  endtask

  task automatic test_back_to_back();
    logic [IDX_W-1:0] sets [3];
    sets[0] = 6'd1; sets[1] = 6'd2; sets[2] = 6'd3;
    for (int k = 0; k < 3; k++)
      do_write('1, sets[k], {$urandom, $urandom, $urandom, $urandom}, 4'hF, 1'b0);
    for (int c = 0; c < 3 + RL; c++) begin
      if (c < 3) begin req = '1; we = 1'b0; addr = sets[c]; end
      else idle();
      @(posedge clk); #1;
      if (c >= RL - 1 && c - (RL - 1) < 3) begin
        checks++;
        if (rvalid !== 1'b1) begin
          errors++; $display("FAIL b2b_rvalid beat=%0d: got %b required 1", c - (RL - 1), rvalid);
        end
        for (int i = 0; i < N_WAY; i++) begin
          last_out[i] = mdl[i][sets[c - (RL - 1)]];
          checks++;
          if (data_way[i] !== last_out[i]) begin
            errors++; $display("FAIL b2b_data beat=%0d way=%0d: got %h required %h", c - (RL - 1), i, data_way[i], last_out[i]);
          end
        end
      end else if (c >= RL - 1) begin
        checks++;
        if (rvalid !== 1'b0) begin
          errors++; $display("FAIL b2b_tail: rvalid=%b required 0", rvalid);
        end
      end
    end
    idle();
  endtask

  task automatic test_random();
    logic [N_WAY-1:0] p;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(N_WAY'($urandom_range(1, 15)), IDX_W'($urandom_range(0, N_SETS - 1)),
                 {$urandom, $urandom, $urandom, $urandom}, N_WORD'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0));
      else
        do_read(N_WAY'($urandom_range(1, 15)), IDX_W'($urandom_range(0, N_SETS - 1)), "random", p);
    end
  endtask

  task automatic test_flush();
    int n;
    do_write('1, 6'd12, PAT, 4'hF, 1'b0);
    req = '1; we = 1'b0; addr = 6'd12; flush = 1'b1;
    @(posedge clk); #1;
    idle();
    for (int i = 0; i < N_WAY; i++) last_out[i] = mdl[i][12];
    model_clear(1'b0);
    n = 0;
    while (n < 300) begin
      if (n == RL - 1) begin
        checks++;
        if (rvalid !== 1'b1 || data_way !== {N_WAY{PAT}}) begin
          errors++; $display("FAIL flush_read: rvalid=%b data=%h required 1 and pattern", rvalid, data_way);
        end
      end
      if (n == 10) begin req = '1; we = 1'b1; addr = 6'd7; wmask = '1; data = '1; end
      if (n == 11) idle();
      if (ready) break;
      @(posedge clk); #1;
      n++;
    end
    idle();
    checks++;
    if (n !== N_SETS) begin
      errors++; $display("FAIL flush_sweep_len: ready after %0d edges required %0d", n, N_SETS);
    end
    read_all("flush_zero");
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    logic [N_WAY-1:0] p;
    do_write('1, 6'd5, PAT, 4'hF, 1'b0);
    req = '1; we = 1'b0; addr = 6'd5; flush = 1'b1;
    @(posedge clk); #1;
    idle();
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0 || init_done !== 1'b0 || rvalid !== 1'b0 || data_way !== '0 || perr_way !== '0) begin
      errors++;
      $display("FAIL midsweep_reset: ready=%b done=%b rvalid=%b data=%h perr=%b required all 0", ready, init_done, rvalid, data_way, perr_way);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear(1'b1);
    wait_ready(n);
    checks++;
    if (n !== N_SETS) begin
      errors++; $display("FAIL midsweep_sweep_len: ready after %0d edges required %0d", n, N_SETS);
    end
    do_read('1, 6'd5, "midsweep_zero", p);
    // A read caught by reset before its response is discarded
    do_write('1, 6'd20, PAT, 4'hF, 1'b0);
    req = '1; we = 1'b0; addr = 6'd20;
    @(posedge clk); #1;
    idle();
    rst = 1'b1;
    #1;
    repeat (2) begin
      checks++;
      if (rvalid !== 1'b0 || data_way !== '0) begin
        errors++; $display("FAIL inflight_discard: rvalid=%b data=%h required 0", rvalid, data_way);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    model_clear(1'b1);
    wait_ready(n);
    checks++;
    if (n !== N_SETS) begin
      errors++; $display("FAIL inflight_sweep_len: ready after %0d edges required %0d", n, N_SETS);
    end
    do_read('1, 6'd20, "inflight_zero", p);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_partial();
    test_parity_inject();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sargantana_idata_memory_banked.md
Name: sargantana_idata_memory_banked

Overview:
- Parametrised N-way instruction-cache data array, successor to the fixed per-way data store.
- Adds per-word write masking, per-word even parity with per-way error flags, a configurable read pipeline (optional output register), and a reset/flush init sweep that zeroes every set.
- Sits between the icache controller (req/we/addr) and the way-select/fetch alignment logic.

Parameters:
- N_WAY, 4, number of ways
- N_SETS, 64, sets per way (power of 2, ≥2)
- LINE_W, 128, line width in bits (multiple of WORD_W)
- WORD_W, 32, mask/parity granule; N_WORD = LINE_W/WORD_W
- OUT_REG, 0, 1 adds an output register stage; read latency RL = 1 + OUT_REG
- Derived: IDX_W = $clog2(N_SETS)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- req_i  in  N_WAY  per-way access request
- we_i  in  1  1 = write, 0 = read (shared by all requested ways)
- wmask_i  in  N_WORD  per-word write enable
- addr_i  in  IDX_W  set index
- data_i  in  LINE_W  write data
- perr_inj_i  in  1  DFT hook: on write, invert stored parity of word 0
- flush_i  in  1  restart init sweep
- ready_o  out  1  access accepted this cycle when high
- rvalid_o  out  1  read data valid
- data_way_o  out  N_WAY x LINE_W  read data, one line per way
- perr_way_o  out  N_WAY  parity error per way, qualified by rvalid_o
- init_done_o  out  1  high once the sweep is complete

Behaviour:
- Interface: single clock clk_i. Reset rst_i is asynchronous, active-high.
- Reset values:
  - state=INIT, sweep cnt=0
  - ready_o=0, init_done_o=0, rvalid_o=0
  - data_way_o=0, perr_way_o=0
  - Pipeline valids cleared.
- FSM INIT:
  - Each edge writes set cnt in all ways: data 0, parity 0.
  - cnt increments each edge.
  - On the edge where cnt==N_SETS-1, go to RUN.
  - ready_o rises exactly N_SETS edges after rst_i deasserts.
- FSM RUN:
  - ready_o=1 (combinational from state).
  - flush_i sampled high: go to INIT next edge, cnt=0.
  - flush_i in INIT restarts cnt at 0.
- Accept: |req_i && ready_o. Requests while ready_o=0 are dropped with no side effects; the requester retries.
- Write (we_i=1):
  - For each requested way and each word w with wmask_i[w]=1: store data word and even parity.
  - If perr_inj_i=1, word 0 parity is stored inverted.
  - No response; rvalid_o stays low.
- Read (we_i=0):
  - Array is read on the accept edge.
  - rvalid_o pulses for one cycle, RL cycles after accept.
  - Only requested ways update data_way_o/perr_way_o. Non-requested ways hold their previous value, and their perr bit reads 0.
  - perr_way_o[i] is the OR over words of (recomputed parity != stored parity).
- Back-to-back reads: one per cycle, fully pipelined, no bubbles.
- Read after write to the same set on the next cycle returns the new data; there is no same-cycle read/write.
- Flush concurrent with an accepted access: the access completes (a read still produces rvalid_o), then the sweep overwrites the array.
- Reads in flight when the sweep starts still deliver rvalid_o.
- Async reset mid-operation: in-flight reads are discarded and no rvalid_o is produced. The array contents are don't-care until the sweep completes.
- cnt is IDX_W+1 bits wide, so there is no wrap at N_SETS-1.

Decomposition:
- Shared package sargantana_icache_pkg gets:
  - typedefs idata_line_t (LINE_W) and idata_par_t (N_WORD)
  - state enum idata_init_state_e {INIT, RUN}
  - function even_parity(word)
- Sub-module sargantana_idata_way_bank: one way; single-port N_SETS x (LINE_W+N_WORD) storage with word-enable, registered read, and parity check. Instantiated N_WAY times by generate.
- The top level holds the FSM, sweep counter, write-data/address mux (sweep vs. user), and the OUT_REG stage.

Test Plan:
- Reset release, idle inputs: ready_o=0 for exactly 64 cycles, then 1. A read of every set in every way returns 0 with perr_way_o=0.
- Write req_i=4'b0101, addr=5, data=0xDEADBEEF_01234567_89ABCDEF_CAFEF00D, wmask=4'hF; then read req_i=4'hF, addr=5:
  - ways 0 and 2 return the pattern, ways 1 and 3 return 0
  - rvalid_o after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1)
- Partial write wmask=4'b0010, data all-ones, to way 1, set 9, then read: line = 0x00000000_00000000_FFFFFFFF_00000000.
- Write with perr_inj_i=1 to way 3, set 0, then read: perr_way_o=4'b1000. Rewrite without injection, read: perr_way_o=0.
- Reads to sets 1, 2, 3 on consecutive cycles: three consecutive rvalid_o pulses with the data in order.
- flush_i with a read accepted in the same cycle: the read's rvalid_o still appears, then ready_o=0 for 64 cycles, then all sets read 0.
- rst_i asserted mid-sweep (cycle 30): outputs clear immediately, and after release ready_o=0 for a full 64 cycles.
